// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce filter and its synchronizer.
package debounce_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } state_e;

    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_STABLE_CYCLES = 1000;

endpackage

// File: rtl/debounce_filter_if.sv
// Signal bundle between a raw-input source and the debounce filter.
// Handshake: none; din is a free-running level, outputs are registered levels/strobes.
interface debounce_filter_if
    import debounce_pkg::*;
#(
    parameter int GLITCH_WIDTH = 8
) ();

    logic                    din;
    logic                    level;
    logic                    rise;
    logic                    fall;
    logic                    settling;
    logic [GLITCH_WIDTH-1:0] glitch_count;
    state_e                  dbg_state;

    modport master (
        output din,
        input  level,
        input  rise,
        input  fall,
        input  settling,
        input  glitch_count,
        input  dbg_state
    );

    modport slave (
        input  din,
        output level,
        output rise,
        output fall,
        output settling,
        output glitch_count,
        output dbg_state
    );

endinterface

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to RESET_VAL.
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_filter.sv
// Synchronizes a bouncy input and commits a new level only after it has held
// for STABLE_CYCLES+1 consecutive edges; counts aborted candidates.
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int   COUNTER_WIDTH = 32,
    parameter logic RESET_LEVEL   = 1'b0,
    parameter int   GLITCH_WIDTH  = 8
) (
    input logic              clk,
    input logic              rst,
    debounce_filter_if.slave bus
);

    localparam logic [63:0] CNT_CAPACITY = (COUNTER_WIDTH >= 64) ? '1
                                         : ((64'd1 << COUNTER_WIDTH) - 64'd1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_TARGET = COUNTER_WIDTH'(STABLE_CYCLES);
    localparam logic [GLITCH_WIDTH-1:0]  GLITCH_MAX = '1;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_filter: SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("debounce_filter: STABLE_CYCLES must be at least 1");
    end
    if (64'(STABLE_CYCLES) > CNT_CAPACITY) begin : g_bad_width
        $error("debounce_filter: COUNTER_WIDTH too small for STABLE_CYCLES");
    end

    logic s;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.din),
        .q_o (s)
    );

    state_e                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     level_q, level_d;
    logic                     rise_q, rise_d;
    logic                     fall_q, fall_d;
    logic [GLITCH_WIDTH-1:0]  glitch_q, glitch_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= STABLE;
            cnt_q    <= '0;
            level_q  <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = glitch_q;
        unique case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (s != level_q) begin
                    state_d = SETTLING;
                    cnt_d   = COUNTER_WIDTH'(1);
                end
            end
            SETTLING: begin
                if (s == level_q) begin
                    // Bounced back before qualifying: abort and record it.
                    state_d = STABLE;
                    cnt_d   = '0;
                    if (glitch_q != GLITCH_MAX) begin
                        glitch_d = glitch_q + GLITCH_WIDTH'(1);
                    end
                end else if (cnt_q == CNT_TARGET) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    level_d = ~level_q;
                    rise_d  = ~level_q;
                    fall_d  = level_q;
                end else begin
                    cnt_d = cnt_q + COUNTER_WIDTH'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.level        = level_q;
    assign bus.rise         = rise_q;
    assign bus.fall         = fall_q;
    assign bus.settling     = (state_q == SETTLING);
    assign bus.glitch_count = glitch_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: three instances (default, narrow glitch counter,
// RESET_LEVEL=1) checked every cycle against a run-length model plus literals.
module tb_debounce_filter;
    import debounce_pkg::*;

    localparam int SS = 2;
    localparam int SC = 4;
    localparam int ND = 3;

    localparam logic M_RL   [ND] = '{1'b0, 1'b0, 1'b1};
    localparam int   M_GMAX [ND] = '{255, 3, 255};

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic din2;

    int checks = 0;
    int errors = 0;
    int rl1_strobes = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    debounce_filter_if #(.GLITCH_WIDTH(8)) if0 ();
    debounce_filter_if #(.GLITCH_WIDTH(2)) if1 ();
    debounce_filter_if #(.GLITCH_WIDTH(8)) if2 ();

    assign if0.din = din;
    assign if1.din = din;
    assign if2.din = din2;

    debounce_filter #(
        .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .COUNTER_WIDTH(8),
        .RESET_LEVEL(1'b0), .GLITCH_WIDTH(8)
    ) dut0 (.clk(clk), .rst(rst), .bus(if0));

    debounce_filter #(
        .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .COUNTER_WIDTH(3),
        .RESET_LEVEL(1'b0), .GLITCH_WIDTH(2)
    ) dut1 (.clk(clk), .rst(rst), .bus(if1));

    debounce_filter #(
        .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .COUNTER_WIDTH(8),
        .RESET_LEVEL(1'b1), .GLITCH_WIDTH(8)
    ) dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic d_level  [ND];
    logic d_rise   [ND];
    logic d_fall   [ND];
    logic d_settle [ND];
    int   d_glitch [ND];

    assign d_level[0]  = if0.level;
    assign d_level[1]  = if1.level;
    assign d_level[2]  = if2.level;
    assign d_rise[0]   = if0.rise;
    assign d_rise[1]   = if1.rise;
    assign d_rise[2]   = if2.rise;
    assign d_fall[0]   = if0.fall;
    assign d_fall[1]   = if1.fall;
    assign d_fall[2]   = if2.fall;
    assign d_settle[0] = if0.settling;
    assign d_settle[1] = if1.settling;
    assign d_settle[2] = if2.settling;
    assign d_glitch[0] = int'(if0.glitch_count);
    assign d_glitch[1] = int'(if1.glitch_count);
    assign d_glitch[2] = int'(if2.glitch_count);

    // ---------------- scoring ----------------
    task automatic chk(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, d, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Raw input reaches the filter SS edges late; a new level is committed
    // once it has differed from the current level on SC+1 consecutive edges.
    logic m_pipe   [ND][SS];
    logic m_level  [ND];
    logic m_rise   [ND];
    logic m_fall   [ND];
    int   m_run    [ND];
    int   m_glitch [ND];

    initial begin
        logic s_seen;
        forever begin
            @(posedge clk or posedge rst);
            for (int d = 0; d < ND; d++) begin
                if (rst) begin
                    for (int i = 0; i < SS; i++) m_pipe[d][i] = M_RL[d];
                    m_level[d]  = M_RL[d];
                    m_rise[d]   = 1'b0;
                    m_fall[d]   = 1'b0;
                    m_run[d]    = 0;
                    m_glitch[d] = 0;
                end else begin
                    s_seen = m_pipe[d][SS-1];
                    for (int i = SS - 1; i > 0; i--) m_pipe[d][i] = m_pipe[d][i-1];
                    m_pipe[d][0] = (d == 2) ? din2 : din;
                    m_rise[d] = 1'b0;
                    m_fall[d] = 1'b0;
                    if (s_seen != m_level[d]) begin
                        m_run[d]++;
                        if (m_run[d] == SC + 1) begin
                            m_level[d] = s_seen;
                            m_rise[d]  = s_seen;
                            m_fall[d]  = !s_seen;
                            m_run[d]   = 0;
                        end
                    end else begin
                        if (m_run[d] > 0 && m_glitch[d] < M_GMAX[d]) m_glitch[d]++;
                        m_run[d] = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic prev_strobe [ND] = '{1'b0, 1'b0, 1'b0};

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                chk("level",    d, int'(d_level[d]),  int'(m_level[d]));
                chk("rise",     d, int'(d_rise[d]),   int'(m_rise[d]));
                chk("fall",     d, int'(d_fall[d]),   int'(m_fall[d]));
                chk("settling", d, int'(d_settle[d]), int'(m_run[d] > 0));
                chk("glitch",   d, d_glitch[d],       m_glitch[d]);
                chk("rise_and_fall", d, int'(d_rise[d] && d_fall[d]), 0);
                if (prev_strobe[d]) chk("strobe_spacing", d, int'(d_rise[d] || d_fall[d]), 0);
                prev_strobe[d] = d_rise[d] || d_fall[d];
            end
            if (d_rise[2] || d_fall[2]) rl1_strobes++;
        end
    end

    // ---------------- driver ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst  = 1'b1;
        din  = 1'b0;
        din2 = 1'b1;
        step(3);
        chk("reset_level",    0, int'(if0.level),    0);
        chk("reset_rise",     0, int'(if0.rise),     0);
        chk("reset_fall",     0, int'(if0.fall),     0);
        chk("reset_settling", 0, int'(if0.settling), 0);
        chk("reset_glitch",   0, d_glitch[0],        0);
        chk("reset_level_rl1", 2, int'(if2.level),   1);

        // Clean rising step, change lands before edge 1.
        rst = 1'b0;
        din = 1'b1;
        step(6);
        chk("step_level_e6",    0, int'(if0.level),    0);
        chk("step_settling_e6", 0, int'(if0.settling), 1);
        step(1);
        chk("step_level_e7", 0, int'(if0.level), 1);
        chk("step_rise_e7",  0, int'(if0.rise),  1);
        step(1);
        chk("step_rise_e8",   0, int'(if0.rise), 0);
        chk("step_glitch_e8", 0, d_glitch[0],    0);

        // Falling step.
        din = 1'b0;
        step(2);
        chk("fall_settling_e2", 0, int'(if0.settling), 0);
        step(1);
        chk("fall_settling_e3", 0, int'(if0.settling), 1);
        step(3);
        chk("fall_settling_e6", 0, int'(if0.settling), 1);
        chk("fall_fall_e6",     0, int'(if0.fall),     0);
        step(1);
        chk("fall_fall_e7",  0, int'(if0.fall),  1);
        chk("fall_level_e7", 0, int'(if0.level), 0);
        step(1);
        chk("fall_fall_e8", 0, int'(if0.fall), 0);

        // Bounce: 1,1,0 then 1 held.
        din = 1'b1;
        step(2);
        din = 1'b0;
        step(1);
        din = 1'b1;
        step(2);
        chk("bounce_glitch_e5",   0, d_glitch[0],        1);
        chk("bounce_settling_e5", 0, int'(if0.settling), 0);
        step(4);
        chk("bounce_level_e9", 0, int'(if0.level), 0);
        step(1);
        chk("bounce_rise_e10",  0, int'(if0.rise),  1);
        chk("bounce_level_e10", 0, int'(if0.level), 1);

        // Reset while a falling candidate is being qualified.
        din = 1'b0;
        step(4);
        chk("midrst_settling_pre", 0, int'(if0.settling), 1);
        rst = 1'b1;
        #1;
        chk("midrst_level",    0, int'(if0.level),    0);
        chk("midrst_settling", 0, int'(if0.settling), 0);
        chk("midrst_fall",     0, int'(if0.fall),     0);
        chk("midrst_glitch",   0, d_glitch[0],        0);
        chk("midrst_level_rl1", 2, int'(if2.level),   1);
        step(2);
        rst = 1'b0;
        step(10);
        chk("postrst_level",  0, int'(if0.level), 0);
        chk("postrst_glitch", 0, d_glitch[0],     0);

        // Saturating glitch counter: five aborted pulses.
        for (int i = 0; i < 5; i++) begin
            din = 1'b1;
            step(2);
            din = 1'b0;
            step(6);
            chk("sat_glitch_w2", 1, d_glitch[1], sat_exp[i]);
            chk("sat_glitch_w8", 0, d_glitch[0], i + 1);
        end

        // RESET_LEVEL=1 instance held at 1 throughout.
        step(20);
        chk("rl1_level",   2, int'(if2.level), 1);
        chk("rl1_strobes", 2, rl1_strobes,     0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
